// File: rtl/signed_mult_arbiter.sv
// Round-robin front end for one shared 11x11 signed Booth multiplier core; owns the core's reset.
// Latency: accept at A -> rsp_valid at A+25 (A+TIMEOUT+1 on timeout); one job in flight.
// Backpressure: reqN_ready only in IDLE; response held in RESP until rsp_ready.
module signed_mult_arbiter #(
    parameter int TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [10:0] req0_m,
    input  logic [10:0] req0_r,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [10:0] req1_m,
    input  logic [10:0] req1_r,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [21:0] rsp_prod,
    output logic        rsp_err,

    output logic        mult_rst,
    output logic [10:0] mult_m,
    output logic [10:0] mult_r,
    input  logic [21:0] mult_out,
    input  logic        mult_valid,

    output logic        busy
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic        id;
        logic [10:0] m;
        logic [10:0] r;
    } op_t;

    state_t             state;
    state_t             state_nxt;
    op_t                op;
    logic               rr_last;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               tmo_hit;
    logic               grant_id;
    logic               accept;
    op_t                grant_op;

    // A lone requester always wins; on contention the one not served last wins.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~rr_last;
        end else begin
            grant_id = ~req0_valid;
        end
        accept = (state == S_IDLE) && (req0_valid || req1_valid);
        grant_op.id = grant_id;
        grant_op.m  = grant_id ? req1_m : req0_m;
        grant_op.r  = grant_id ? req1_r : req0_r;
    end

    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept &&  grant_id;

    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept)                state_nxt = S_RUN;
            S_RUN:  if (mult_valid || tmo_hit) state_nxt = S_RESP;
            S_RESP: if (rsp_ready)             state_nxt = S_IDLE;
            default:                           state_nxt = S_IDLE;
        endcase
    end

    // The core has no start input, so releasing its reset is what launches a job.
    always_comb begin
        mult_rst  = 1'b1;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: busy      = 1'b0;
            S_RUN:  mult_rst  = 1'b0;
            S_RESP: rsp_valid = 1'b1;
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op       <= '0;
            rr_last  <= 1'b1;
            tmo_cnt  <= '0;
            rsp_prod <= '0;
            rsp_err  <= 1'b0;
            rsp_id   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op      <= grant_op;
                        tmo_cnt <= '0;
                    end
                end
                S_RUN: begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                    if (mult_valid) begin
                        rsp_prod <= mult_out;
                        rsp_err  <= 1'b0;
                        rsp_id   <= op.id;
                    end else if (tmo_hit) begin
                        rsp_prod <= '0;
                        rsp_err  <= 1'b1;
                        rsp_id   <= op.id;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rr_last <= op.id;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operands come from the latched job only, never straight from the request ports.
    assign mult_m = op.m;
    assign mult_r = op.r;

endmodule

// File: tb/tb_signed_mult_arbiter.sv
// Bench for signed_mult_arbiter: behavioural Booth-core timing model plus a response scoreboard.
`timescale 1ns/1ps
module tb_signed_mult_arbiter;

    localparam int TIMEOUT = 40;
    localparam int LAT     = 25;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [10:0] req0_m, req0_r, req1_m, req1_r;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [21:0] rsp_prod;
    logic        mult_rst, mult_valid, busy;
    logic [10:0] mult_m, mult_r;
    logic [21:0] mult_out;

    always #5 clk = ~clk;

    signed_mult_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_m(req0_m), .req0_r(req0_r),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_m(req1_m), .req1_r(req1_r),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_prod(rsp_prod), .rsp_err(rsp_err),
        .mult_rst(mult_rst), .mult_m(mult_m), .mult_r(mult_r),
        .mult_out(mult_out), .mult_valid(mult_valid), .busy(busy)
    );

    // Core model: one IDLE cycle plus 22 CAL/SHIFT cycles after reset release, then DONE.
    logic [4:0]         core_cnt;
    bit                 stuck = 1'b0;
    logic signed [21:0] core_prod;
    always @(posedge clk) begin
        if (mult_rst)              core_cnt <= 5'd0;
        else if (core_cnt != 5'd23) core_cnt <= core_cnt + 5'd1;
    end
    assign core_prod  = $signed(mult_m) * $signed(mult_r);
    assign mult_valid = !mult_rst && (core_cnt == 5'd23) && !stuck;
    assign mult_out   = mult_valid ? core_prod : 22'h2AAAAA;

    typedef struct { logic [10:0] m; logic [10:0] r; logic [21:0] p; } op_t;
    typedef struct { bit id; logic [10:0] m; logic [10:0] r; logic [21:0] p; bit err; int lat; } exp_t;

    op_t  q0[$];
    op_t  q1[$];
    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic op_t mk(input int m, input int r);
        op_t o;
        logic signed [10:0] sm, sr;
        sm  = m[10:0];
        sr  = r[10:0];
        o.m = sm;
        o.r = sr;
        o.p = sm * sr;
        return o;
    endfunction

    function automatic op_t mkd(input int m, input int r, input logic [21:0] p);
        op_t o;
        o.m = m[10:0];
        o.r = r[10:0];
        o.p = p;
        return o;
    endfunction

    // Requester drivers: present the queue head, hold it until the monitor retires it.
    initial begin
        req0_valid = 1'b0; req0_m = '0; req0_r = '0;
        req1_valid = 1'b0; req1_m = '0; req1_r = '0;
        forever begin
            @(posedge clk); #1;
            req0_valid = (q0.size() > 0);
            if (q0.size() > 0) begin req0_m = q0[0].m; req0_r = q0[0].r; end
            req1_valid = (q1.size() > 0);
            if (q1.size() > 0) begin req1_m = q1[0].m; req1_r = q1[0].r; end
        end
    end

    // Reference model of the arbiter, checked every cycle on the falling edge.
    bit   model_busy = 1'b0;
    bit   model_rr   = 1'b1;
    int   acc_cyc    = 0;
    bit   g_vld, g_id, exp_rv;
    int   el;
    exp_t e, ne;
    op_t  o;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_busy",      busy,      0);
            chk("rst_mult_rst",  mult_rst,  1);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_err",   rsp_err,   0);
            chk("rst_rsp_id",    rsp_id,    0);
            chk("rst_rsp_prod",  rsp_prod,  0);
            chk("rst_mult_m",    mult_m,    0);
            chk("rst_mult_r",    mult_r,    0);
            model_busy = 1'b0;
            model_rr   = 1'b1;
            sb.delete();
        end else begin
            g_id  = (req0_valid && req1_valid) ? !model_rr : !req0_valid;
            g_vld = !model_busy && (req0_valid || req1_valid);
            chk("req0_ready", req0_ready, g_vld && !g_id);
            chk("req1_ready", req1_ready, g_vld &&  g_id);
            chk("busy",       busy,       model_busy);
            if (model_busy) begin
                e      = sb[0];
                el     = cyc - acc_cyc;
                exp_rv = (el >= e.lat);
                chk("rsp_valid", rsp_valid, exp_rv);
                chk("mult_rst",  mult_rst,  exp_rv);
                chk("mult_m",    mult_m,    e.m);
                chk("mult_r",    mult_r,    e.r);
                if (exp_rv) begin
                    chk("rsp_id",   rsp_id,   e.id);
                    chk("rsp_prod", rsp_prod, e.p);
                    chk("rsp_err",  rsp_err,  e.err);
                    if (rsp_ready) begin
                        model_rr   = e.id;
                        model_busy = 1'b0;
                        void'(sb.pop_front());
                    end
                end
            end else begin
                chk("idle_rsp_valid", rsp_valid, 0);
                chk("idle_mult_rst",  mult_rst,  1);
            end
            if (g_vld) begin
                if (g_id) o = q1.pop_front();
                else      o = q0.pop_front();
                ne.id  = g_id;
                ne.m   = o.m;
                ne.r   = o.r;
                ne.err = stuck;
                ne.p   = stuck ? 22'h0 : o.p;
                ne.lat = stuck ? TIMEOUT + 1 : LAT;
                sb.push_back(ne);
                model_busy = 1'b1;
                acc_cyc    = cyc;
            end
        end
    end

    task automatic drain(input int maxc);
        int k;
        k = 0;
        while ((q0.size() > 0 || q1.size() > 0 || model_busy) && k < maxc) begin
            @(posedge clk); #2;
            k++;
        end
        chk("drain", (q0.size() == 0 && q1.size() == 0 && !model_busy), 1);
    endtask

    op_t dir_tab[4];

    initial begin
        int k;
        reset     = 1'b1;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // Single job and signed / extreme operands
        dir_tab[0] = mkd(3, 5, 22'h00000F);
        dir_tab[1] = mkd(-7, 6, 22'h3FFFD6);
        dir_tab[2] = mkd(-1024, -1024, 22'h100000);
        dir_tab[3] = mkd(1023, -1024, 22'h300400);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) q1.push_back(dir_tab[i]);
            else        q0.push_back(dir_tab[i]);
            drain(200);
        end

        // Contention: both requesters valid back to back
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk($urandom_range(0, 2047), $urandom_range(0, 2047)));
            q1.push_back(mk($urandom_range(0, 2047), $urandom_range(0, 2047)));
        end
        drain(600);

        // Response backpressure with a request waiting
        rsp_ready = 1'b0;
        q1.push_back(mk(-300, 517));
        k = 0;
        while (!rsp_valid && k < 60) begin @(posedge clk); #2; k++; end
        chk("bp_rsp_seen", rsp_valid, 1);
        q0.push_back(mk(111, -222));
        repeat (10) @(posedge clk);
        #2 rsp_ready = 1'b1;
        drain(200);

        // Timeout followed by a normal job
        stuck = 1'b1;
        q0.push_back(mk(45, 45));
        drain(200);
        stuck = 1'b0;
        q1.push_back(mk(-512, 2));
        drain(200);

        // Reset in the middle of a job
        q1.push_back(mk(9, 9));
        k = 0;
        while (!model_busy && k < 20) begin @(posedge clk); #2; k++; end
        chk("mid_accept", model_busy, 1);
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        q0.delete();
        q1.delete();
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        q0.push_back(mk(-1, -1));
        q1.push_back(mk(1000, 3));
        drain(200);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/signed_mult_arbiter.md
# signed_mult_arbiter

Two-requester round-robin scheduler that shares one `signed_mult` Booth core, an 11×11 signed multiplier with no start input. The block accepts operand pairs over valid/ready handshakes and latches them. It starts each job by pulsing the core's reset, waits for the core's `valid`, and returns the 22-bit product with the requester ID on a single response channel. It sits between the datapath clients and the multiplier instance, and it owns that instance's reset.

## Interface
Parameters:
- `TIMEOUT`, default 40: cycles in RUN without `mult_valid` before the job is aborted with an error. Must be >24.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `req0_valid`, in, 1: requester 0 has an operand pair.
- `req0_ready`, out, 1: requester 0 accepted this cycle.
- `req0_m`, in, 11: requester 0 multiplicand, signed.
- `req0_r`, in, 11: requester 0 multiplier, signed.
- `req1_valid`, `req1_ready`, `req1_m`, `req1_r`: same meanings for requester 1.
- `rsp_valid`, out, 1: response held.
- `rsp_ready`, in, 1: consumer takes the response.
- `rsp_id`, out, 1: requester that owns the response.
- `rsp_prod`, out, 22: signed product.
- `rsp_err`, out, 1: the job timed out; `rsp_prod` is 0.
- `mult_rst`, out, 1: drives the core's `reset`.
- `mult_m`, out, 11: drives the core's `m`.
- `mult_r`, out, 11: drives the core's `r`.
- `mult_out`, in, 22: core `out`.
- `mult_valid`, in, 1: core `valid`.
- `busy`, out, 1: state is not IDLE.

## Operation
States:
- **IDLE**
  - `mult_rst`=1.
  - Grant logic drives `reqN_ready` combinationally. Only the granted requester sees ready=1, and only if its valid=1.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester other than the last-served one (`rr_last`) is granted. After reset, `rr_last`=1, so requester 0 wins first.
  - On accept, latch m, r and id into `op_m`, `op_r` and `op_id`, clear the timeout counter, and go to RUN.
- **RUN**
  - `mult_rst`=0, and `mult_m`/`mult_r` equal the latched operands, stable for the whole state.
  - The timeout counter increments each cycle.
  - If `mult_valid`=1: capture `mult_out` into `rsp_prod`, set `rsp_err`=0, and go to RESP.
  - Else if the counter reaches `TIMEOUT`-1: set `rsp_prod`=0, `rsp_err`=1, and go to RESP.
- **RESP**
  - `mult_rst`=1 and `rsp_valid`=1.
  - `rsp_prod`, `rsp_id` and `rsp_err` are held stable until `rsp_ready`=1.
  - On handshake: `rr_last`←`op_id`, then go to IDLE.

Rules:
- `mult_m`/`mult_r` output the latched registers in every state; they do not feed through from the requester ports.
- `mult_valid` is ignored outside RUN.
- Requesters must hold m/r stable while valid=1 and ready=0. The block does not buffer more than one job.

## Timing
- Reset values:
  - state=IDLE, `rr_last`=1, `mult_rst`=1.
  - `busy`, `rsp_valid`, `rsp_err` and `rsp_id` are 0.
  - `rsp_prod`, `mult_m` and `mult_r` are 0.
  - `req*_ready` are 0 unless a valid is present. Ready is combinational from IDLE and valid.
- Latency, with accept at cycle A:
  - RUN covers A+1…A+24. The core spends 1 cycle in its IDLE state, then 11 CAL/SHIFT pairs (22 cycles), then reaches DONE, so `mult_valid` is first seen at A+24.
  - `rsp_valid`=1 from A+25.
- Throughput:
  - A response accepted at cycle B puts the block in IDLE at B+1, which is the earliest next accept.
  - Job spacing is therefore ≥26 cycles with `rsp_ready` tied high.
- Timeout: `rsp_valid` asserts at A+`TIMEOUT`+1.
- `reset` mid-job: everything returns to reset values immediately. The pending job and response are dropped and must be re-issued.
- Both valid while busy: no ready; both requesters wait. Fairness is then decided on return to IDLE.
- Arithmetic:
  - Two's complement throughout.
  - The 11-bit range is −1024…1023.
  - The product range −1047552…1048576 fits in 22 bits, so there is no overflow.

## Test plan
- **Single job, requester 0.** m=3, r=5 → ready at A; `rsp_valid` at A+25; `rsp_prod`=15; `rsp_id`=0; `rsp_err`=0.
- **Signed and extreme operands.**
  - m=−7, r=6 → `rsp_prod`=22'h3FFFD6 (−42).
  - m=−1024, r=−1024 → 22'h100000.
  - m=1023, r=−1024 → 22'h300400.
- **Contention.** Both valid continuously, with distinct operands → grants alternate 0,1,0,1. Each response carries the correct id and product. Ready is never high for both requesters in the same cycle.
- **Backpressure.** `rsp_ready`=0 for 10 cycles after `rsp_valid` → outputs stay stable, `req*_ready` stays 0, `mult_rst`=1. The handshake completes on the cycle `rsp_ready` rises.
- **Timeout.** Tie `mult_valid`=0 → `rsp_valid` at A+41 with `rsp_err`=1 and `rsp_prod`=0. The next job still completes normally.
- **Mid-job reset.** Assert `reset` at A+10 → `busy`=0, `mult_rst`=1 and `rsp_valid`=0 immediately. After release, the first grant goes to requester 0.
